lsu_fsm: RTL and testbench

LSU_FSM -- requirements
Module: lsu_fsm

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_fsm_load_align.sv | 27 ++
 rtl/lsu_fsm.sv | 184 ++++++++++++++++++
 tb/tb_lsu_fsm.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit FSM and its lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  localparam logic [2:0] MEMOP_NONE = 3'b111;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;
  localparam logic [63:0] CLINT_LAST_DEF = 64'h0000_0000_0200_BFFF;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic addr_misaligned(input logic [2:0] lo, input logic [1:0] size);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo[1:0];
      default: return |lo[2:0];
    endcase
  endfunction

endpackage

// File: rtl/lsu_fsm_load_align.sv
// Byte-lane extraction and sign/zero extension for load data (cache and CLINT).
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned OFFW = 3
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [1:0]      size,
  input  logic            sext,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SIZE_B:  data = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      SIZE_W:  data = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_fsm.sv
// Load/store unit sequencer: captures an op, routes it to the cache or CLINT,
// and holds the aligned result for writeback.
module lsu_fsm
  import lsu_pkg::*;
#(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     FWD_W      = 256,
  parameter logic [XLEN-1:0] CLINT_BASE = XLEN'(CLINT_BASE_DEF),
  parameter logic [XLEN-1:0] CLINT_LAST = XLEN'(CLINT_LAST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [2:0]        lsu_memop,
  input  logic              lsu_we,
  input  logic [FWD_W-1:0]  lsu_fwd,
  output logic              cache_req_valid,
  input  logic              cache_req_ready,
  output logic [XLEN-1:0]   cache_req_addr,
  output logic              cache_req_we,
  output logic [XLEN-1:0]   cache_req_wdata,
  output logic [XLEN/8-1:0] cache_req_wstrb,
  input  logic              cache_rvalid,
  input  logic [XLEN-1:0]   cache_rdata,
  output logic              clint_re,
  output logic              clint_we,
  output logic [XLEN-1:0]   clint_addr,
  output logic [XLEN-1:0]   clint_wdata,
  input  logic [XLEN-1:0]   clint_rdata,
  output logic              wb_valid,
  input  logic              wb_allowin,
  output logic [XLEN-1:0]   wb_memout,
  output logic              wb_misalign,
  output logic [FWD_W-1:0]  wb_fwd
);

  localparam int unsigned SW   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(SW);

  lsu_state_e        state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic              we_q, we_d;
  logic [2:0]        memop_q, memop_d;
  logic [FWD_W-1:0]  fwd_q, fwd_d;
  logic [XLEN-1:0]   memout_q, memout_d;
  logic              misalign_q, misalign_d;

  logic              accept;
  logic              is_clint;
  logic              cap_none;
  logic              cap_misal;
  logic [OFFW-1:0]   cap_off;
  logic [XLEN-1:0]   cap_wmask;
  logic [SW-1:0]     cap_smask;
  logic [XLEN-1:0]   cap_wdata;
  logic [SW-1:0]     cap_wstrb;
  logic [XLEN-1:0]   lane_src;
  logic [XLEN-1:0]   lane_data;

  assign lsu_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_allowin);
  assign accept    = lsu_valid && lsu_ready;
  assign is_clint  = (addr_q >= CLINT_BASE) && (addr_q <= CLINT_LAST);

  // Store data and strobes are formatted at capture so the request is stable in REQ.
  always_comb begin
    cap_off   = lsu_addr[OFFW-1:0];
    cap_none  = (lsu_memop == MEMOP_NONE);
    cap_misal = addr_misaligned(lsu_addr[2:0], lsu_memop[1:0]);
    case (lsu_memop[1:0])
      SIZE_B:  begin cap_wmask = XLEN'(8'hFF);         cap_smask = SW'(1);    end
      SIZE_H:  begin cap_wmask = XLEN'(16'hFFFF);      cap_smask = SW'(3);    end
      SIZE_W:  begin cap_wmask = XLEN'(32'hFFFF_FFFF); cap_smask = SW'(15);   end
      default: begin cap_wmask = '1;                   cap_smask = '1;        end
    endcase
    cap_wdata = (lsu_wdata & cap_wmask) << {cap_off, 3'b000};
    cap_wstrb = cap_smask << cap_off;
  end

  // CLINT data is only consumed in REQ; cache data only in WAIT.
  assign lane_src = (state_q == ST_REQ) ? clint_rdata : cache_rdata;

  load_align #(
    .XLEN (XLEN),
    .OFFW (OFFW)
  ) u_load_align (
    .rdata  (lane_src),
    .offset (addr_q[OFFW-1:0]),
    .size   (memop_q[1:0]),
    .sext   (memop_q[2]),
    .data   (lane_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    memop_d    = memop_q;
    fwd_d      = fwd_q;
    memout_d   = memout_q;
    misalign_d = misalign_q;

    case (state_q)
      ST_REQ: begin
        if (is_clint) begin
          state_d  = ST_DONE;
          memout_d = we_q ? '0 : lane_data;
        end else if (cache_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cache_rvalid) begin
          state_d  = ST_DONE;
          memout_d = we_q ? '0 : lane_data;
        end
      end
      ST_DONE: begin
        if (wb_allowin) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Accept only happens in IDLE or DONE, so it overrides the DONE exit above.
    if (accept) begin
      addr_d     = lsu_addr;
      wdata_d    = cap_wdata;
      wstrb_d    = cap_wstrb;
      we_d       = lsu_we;
      memop_d    = lsu_memop;
      fwd_d      = lsu_fwd;
      memout_d   = '0;
      misalign_d = !cap_none && cap_misal;
      state_d    = (cap_none || cap_misal) ? ST_DONE : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      memop_q    <= MEMOP_NONE;
      fwd_q      <= '0;
      memout_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      we_q       <= we_d;
      memop_q    <= memop_d;
      fwd_q      <= fwd_d;
      memout_q   <= memout_d;
      misalign_q <= misalign_d;
    end
  end

  assign cache_req_valid = (state_q == ST_REQ) && !is_clint;
  assign cache_req_addr  = addr_q;
  assign cache_req_we    = we_q;
  assign cache_req_wdata = wdata_q;
  assign cache_req_wstrb = wstrb_q;

  assign clint_re    = (state_q == ST_REQ) && is_clint && !we_q;
  assign clint_we    = (state_q == ST_REQ) && is_clint && we_q;
  assign clint_addr  = addr_q;
  assign clint_wdata = wdata_q;

  assign wb_valid    = (state_q == ST_DONE);
  assign wb_memout   = memout_q;
  assign wb_misalign = misalign_q;
  assign wb_fwd      = fwd_q;

endmodule

// File: tb/tb_lsu_fsm.sv
// Scoreboard bench for lsu_fsm: random ops against a byte-level reference model.
module tb_lsu_fsm;

  logic         clk = 1'b0;
  logic         rst;
  logic         lsu_valid;
  logic         lsu_ready;
  logic [63:0]  lsu_addr;
  logic [63:0]  lsu_wdata;
  logic [2:0]   lsu_memop;
  logic         lsu_we;
  logic [255:0] lsu_fwd;
  logic         cache_req_valid;
  logic         cache_req_ready;
  logic [63:0]  cache_req_addr;
  logic         cache_req_we;
  logic [63:0]  cache_req_wdata;
  logic [7:0]   cache_req_wstrb;
  logic         cache_rvalid;
  logic [63:0]  cache_rdata;
  logic         clint_re;
  logic         clint_we;
  logic [63:0]  clint_addr;
  logic [63:0]  clint_wdata;
  logic [63:0]  clint_rdata;
  logic         wb_valid;
  logic         wb_allowin;
  logic [63:0]  wb_memout;
  logic         wb_misalign;
  logic [255:0] wb_fwd;

  always #5 clk = ~clk;

  lsu_fsm #(
    .XLEN  (64),
    .FWD_W (256)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_valid       (lsu_valid),
    .lsu_ready       (lsu_ready),
    .lsu_addr        (lsu_addr),
    .lsu_wdata       (lsu_wdata),
    .lsu_memop       (lsu_memop),
    .lsu_we          (lsu_we),
    .lsu_fwd         (lsu_fwd),
    .cache_req_valid (cache_req_valid),
    .cache_req_ready (cache_req_ready),
    .cache_req_addr  (cache_req_addr),
    .cache_req_we    (cache_req_we),
    .cache_req_wdata (cache_req_wdata),
    .cache_req_wstrb (cache_req_wstrb),
    .cache_rvalid    (cache_rvalid),
    .cache_rdata     (cache_rdata),
    .clint_re        (clint_re),
    .clint_we        (clint_we),
    .clint_addr      (clint_addr),
    .clint_wdata     (clint_wdata),
    .clint_rdata     (clint_rdata),
    .wb_valid        (wb_valid),
    .wb_allowin      (wb_allowin),
    .wb_memout       (wb_memout),
    .wb_misalign     (wb_misalign),
    .wb_fwd          (wb_fwd)
  );

  typedef struct {
    logic [63:0]  memout;
    logic         misal;
    logic [255:0] fwd;
  } wb_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [7:0]  wstrb;
    int unsigned rdy;
    int unsigned rv;
  } c_exp_t;

  wb_exp_t wbq[$];
  c_exp_t  cq[$];

  int n_cmp = 0;
  int n_err = 0;
  int exp_clint_re = 0, exp_clint_we = 0;
  int got_clint_re = 0, got_clint_we = 0;
  int stall_req = 0;
  bit resp_busy = 0;
  bit in_wait = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    w = {a[63:3], 3'b000};
    if (w == 64'h8000_0000) return 64'h1122_3344_8055_6677;
    return (w * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_3C3C_A5A5_5A5A;
  endfunction

  function automatic logic [63:0] clint_word(input logic [63:0] a);
    if (a == 64'h0200_BFF8) return 64'h1234;
    return ({a[63:3], 3'b000} * 64'hC2B2_AE3D_27D4_EB4F) ^ 64'h5555_0000_AAAA_FFFF;
  endfunction

  always_comb clint_rdata = clint_word(clint_addr);

  // Reference: gather nbytes bytes starting at the byte offset, then extend.
  function automatic logic [63:0] exp_load(input logic [63:0] word, input logic [63:0] a,
                                           input logic [2:0] memop);
    int unsigned nb, off;
    logic [63:0] v;
    nb  = 1 << memop[1:0];
    off = a[2:0];
    v   = '0;
    for (int unsigned i = 0; i < nb; i++)
      v |= ((word >> (8 * (off + i))) & 64'hFF) << (8 * i);
    if (memop[2] && nb < 8 && v[8*nb-1]) v |= ~64'd0 << (8 * nb);
    return v;
  endfunction

  task automatic issue(input logic [2:0] memop, input logic [63:0] a, input logic we,
                       input logic [63:0] wdata, input logic [255:0] fwd,
                       input int unsigned rdy, input int unsigned rv);
    int unsigned nb, off;
    bit none, misal, clint, acc;
    wb_exp_t w;
    c_exp_t  c;
    nb    = 1 << memop[1:0];
    off   = a[2:0];
    none  = (memop == 3'b111);
    misal = !none && ((a % nb) != 0);
    clint = (a >= 64'h0200_0000) && (a <= 64'h0200_BFFF);
    w.fwd   = fwd;
    w.misal = misal;
    if (none || misal || we) w.memout = '0;
    else w.memout = exp_load(clint ? clint_word(a) : mem_word(a), a, memop);
    wbq.push_back(w);
    if (!none && !misal) begin
      if (clint) begin
        if (we) exp_clint_we++; else exp_clint_re++;
      end else begin
        c.addr  = a;
        c.we    = we;
        c.wstrb = 8'(((1 << nb) - 1) << off);
        c.wmask = (nb == 8) ? ~64'd0 : (((64'd1 << (8 * nb)) - 1) << (8 * off));
        c.wdata = (wdata << (8 * off)) & c.wmask;
        c.rdy   = rdy;
        c.rv    = rv;
        cq.push_back(c);
      end
    end
    lsu_valid = 1'b1;
    lsu_addr  = a;
    lsu_memop = memop;
    lsu_we    = we;
    lsu_wdata = wdata;
    lsu_fwd   = fwd;
    acc = 0;
    for (int c2 = 0; c2 < 300 && !acc; c2++) begin
      #1 acc = lsu_ready;
      @(negedge clk);
    end
    lsu_valid = 1'b0;
    lsu_addr  = {$urandom(), $urandom()};
    if (!acc) begin
      $display("FAIL accept_timeout actual=0 required=1");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $fatal(1, "accept timeout");
    end
    if (none || misal) chk("fast_latency", wb_valid, 1'b1);
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 500; c++) begin
      @(negedge clk);
      if (wbq.size() == 0 && !resp_busy) break;
    end
    chk("drain_timeout", wbq.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [255:0] rnd_fwd();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom();
    return f;
  endfunction

  // Cache model: per-request ready/response latency taken from the expectation.
  initial begin
    c_exp_t e;
    cache_req_ready = 1'b0;
    cache_rvalid    = 1'b0;
    cache_rdata     = '0;
    forever begin
      @(negedge clk);
      cache_rvalid    = 1'b0;
      cache_req_ready = 1'b0;
      if (cache_req_valid) begin
        resp_busy = 1;
        if (cq.size() == 0) begin
          chk("unexpected_cache_req", cache_req_valid, 1'b0);
          e.addr = cache_req_addr; e.we = cache_req_we; e.wstrb = cache_req_wstrb;
          e.wmask = '0; e.wdata = '0; e.rdy = 0; e.rv = 0;
        end else begin
          e = cq.pop_front();
        end
        chk("req_addr", cache_req_addr, e.addr);
        chk("req_we", cache_req_we, e.we);
        if (e.we) begin
          chk("req_wstrb", cache_req_wstrb, e.wstrb);
          chk("req_wdata", cache_req_wdata & e.wmask, e.wdata);
        end
        repeat (e.rdy) begin
          @(negedge clk);
          chk("req_hold_valid", cache_req_valid, 1'b1);
          chk("req_hold_addr", cache_req_addr, e.addr);
          chk("early_wb", wb_valid, 1'b0);
        end
        cache_req_ready = 1'b1;
        @(negedge clk);
        cache_req_ready = 1'b0;
        chk("req_drop", cache_req_valid, 1'b0);
        in_wait = 1;
        repeat (e.rv) begin
          @(negedge clk);
          chk("early_wb", wb_valid, 1'b0);
        end
        in_wait = 0;
        cache_rvalid = 1'b1;
        cache_rdata  = mem_word(e.addr);
        resp_busy = 0;
      end else if (rst && $urandom_range(0, 7) == 0) begin
        cache_rvalid = 1'b1;
        cache_rdata  = {$urandom(), $urandom()};
      end
    end
  end

  // Writeback monitor: randomised backpressure, hold checks, scoreboard pop.
  initial begin
    wb_exp_t      w;
    bit           stall_prev;
    logic [63:0]  sv_memout;
    logic         sv_misal;
    logic [255:0] sv_fwd;
    wb_allowin = 1'b0;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (stall_prev) begin
          chk("hold_memout", wb_memout, sv_memout);
          chk("hold_misalign", wb_misalign, sv_misal);
          chk("hold_fwd", wb_fwd, sv_fwd);
        end
        if (stall_req > 0) begin
          wb_allowin = 1'b0;
          stall_req--;
        end else begin
          wb_allowin = ($urandom_range(0, 3) != 0);
        end
        #1 chk("ready_in_done", lsu_ready, wb_allowin);
        if (wb_allowin) begin
          stall_prev = 0;
          if (wbq.size() == 0) begin
            chk("unexpected_wb", wb_valid, 1'b0);
          end else begin
            w = wbq.pop_front();
            chk("wb_memout", wb_memout, w.memout);
            chk("wb_misalign", wb_misalign, w.misal);
            chk("wb_fwd", wb_fwd, w.fwd);
          end
        end else begin
          stall_prev = 1;
          sv_memout  = wb_memout;
          sv_misal   = wb_misalign;
          sv_fwd     = wb_fwd;
        end
      end else begin
        wb_allowin = 1'($urandom_range(0, 1));
        stall_prev = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (clint_re) got_clint_re++;
    if (clint_we) got_clint_we++;
    if (clint_re || clint_we) chk("clint_vs_cache", cache_req_valid, 1'b0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bnd [5];
    logic [63:0] a;
    int wait_c;
    bnd[0] = 64'h01FF_FFF8; bnd[1] = 64'h0200_0000; bnd[2] = 64'h0200_BFF8;
    bnd[3] = 64'h0200_BFFF; bnd[4] = 64'h0200_C000;

    rst = 1'b0; lsu_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    lsu_memop = 3'b111; lsu_we = 1'b0; lsu_fwd = '0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_cache_req", cache_req_valid, 1'b0);
    chk("rst_clint_re", clint_re, 1'b0);
    chk("rst_clint_we", clint_we, 1'b0);
    chk("rst_memout", wb_memout, 64'd0);
    chk("rst_misalign", wb_misalign, 1'b0);
    chk("rst_fwd", wb_fwd, 256'd0);
    rst = 1'b1;
    #1 chk("rst_ready", lsu_ready, 1'b1);
    @(negedge clk);

    issue(3'b111, 64'h8000_0010, 1'b0, 64'h0, rnd_fwd(), 0, 0);
    drain();
    issue(3'b100, 64'h8000_0003, 1'b0, 64'h0, rnd_fwd(), 2, 3);
    drain();
    issue(3'b001, 64'h8000_0006, 1'b1, 64'hBEEF, rnd_fwd(), 1, 1);
    drain();
    issue(3'b010, 64'h8000_0002, 1'b0, 64'h0, rnd_fwd(), 0, 0);
    drain();
    issue(3'b011, 64'h0200_BFF8, 1'b0, 64'h0, rnd_fwd(), 0, 0);
    drain();
    chk("clint_single_pulse", got_clint_re, 1);

    stall_req = 4;
    issue(3'b000, 64'h8000_0021, 1'b0, 64'h0, rnd_fwd(), 0, 0);
    drain();

    // Reset while waiting for a cache response; the late rvalid must be ignored.
    issue(3'b011, 64'h8000_0040, 1'b0, 64'h0, rnd_fwd(), 0, 15);
    for (wait_c = 0; wait_c < 50 && !in_wait; wait_c++) @(negedge clk);
    chk("reach_wait", in_wait, 1'b1);
    rst = 1'b0;
    void'(wbq.pop_back());
    #1;
    chk("abort_wb_valid", wb_valid, 1'b0);
    chk("abort_cache_req", cache_req_valid, 1'b0);
    chk("abort_clint", {clint_re, clint_we}, 2'b00);
    chk("abort_memout", wb_memout, 64'd0);
    chk("abort_fwd", wb_fwd, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_ready", lsu_ready, 1'b1);
    for (wait_c = 0; wait_c < 50 && resp_busy; wait_c++) @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("stray_rvalid_ignored", wb_valid, 1'b0);
    end

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 64'h0200_0000 + 64'($urandom_range(0, 32'hBFFF));
        1:       a = bnd[$urandom_range(0, 4)];
        default: a = 64'h8000_0000 + 64'($urandom_range(0, 4095));
      endcase
      issue(3'($urandom_range(0, 7)), a, 1'($urandom_range(0, 1)),
            {$urandom(), $urandom()}, rnd_fwd(), $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    chk("clint_re_count", got_clint_re, exp_clint_re);
    chk("clint_we_count", got_clint_we, exp_clint_we);
    chk("cache_queue_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
